// File: rtl/spi_master_ctrl.sv
// SPI mode-0 transaction master for the 4 x 8-bit SPI slave register block.
// Sends a command byte plus 1-4 data bytes; returns read data with a done pulse.
module spi_master_ctrl #(
  parameter int CLK_DIV  = 50,
  parameter int READ_GAP = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        rw,
  input  logic [1:0]  addr,
  input  logic [1:0]  len,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic        SS
);

  localparam int MAXV = (CLK_DIV > READ_GAP) ? CLK_DIV : READ_GAP;
  localparam int CW   = $clog2(MAXV);

  localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_GAP  = CW'(READ_GAP - 1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_CMD,
    S_GAP,
    S_DATA,
    S_HOLD,
    S_RECOVER
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [1:0]    r_byte;
  logic [1:0]    r_len;
  logic          r_rw;
  logic [7:0]    r_sh;
  logic [7:0]    r_rx;
  logic [31:0]   r_wd;
  logic [31:0]   r_rbuf;

  logic w_cnt_zero;
  logic w_last_bit;
  logic w_last_byte;

  assign w_cnt_zero  = (r_cnt == '0);
  assign w_last_bit  = (r_bit == 3'd0);
  assign w_last_byte = (r_byte == r_len);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= 3'd7;
      r_byte  <= 2'd0;
      r_len   <= 2'd0;
      r_rw    <= 1'b0;
      r_sh    <= 8'h00;
      r_rx    <= 8'h00;
      r_wd    <= 32'h0;
      r_rbuf  <= 32'h0;
      rdata   <= 32'h0;
      busy    <= 1'b0;
      done    <= 1'b0;
      SCLK    <= 1'b0;
      MOSI    <= 1'b0;
      SS      <= 1'b1;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_SETUP;
            r_rw    <= rw;
            r_len   <= len;
            r_wd    <= rw ? wdata : 32'h0;
            r_rbuf  <= 32'h0;
            r_cnt   <= C_HALF;
            r_bit   <= 3'd7;
            r_byte  <= 2'd0;
            // command byte is {rw, 5'b0, addr}; bit 7 goes out with SS
            MOSI    <= rw;
            r_sh    <= {5'b00000, addr, 1'b0};
            SCLK    <= 1'b0;
            SS      <= 1'b0;
            busy    <= 1'b1;
          end
        end
        S_SETUP: begin
          if (w_cnt_zero) begin
            r_state <= S_CMD;
            SCLK    <= 1'b1;
            r_rx    <= {r_rx[6:0], MISO};
            r_cnt   <= C_HALF;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_CMD, S_DATA: begin
          if (!w_cnt_zero) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!SCLK) begin
            SCLK  <= 1'b1;
            r_rx  <= {r_rx[6:0], MISO};
            r_cnt <= C_HALF;
          end else begin
            SCLK  <= 1'b0;
            r_cnt <= C_HALF;
            if (!w_last_bit) begin
              r_bit <= r_bit - 1'b1;
              MOSI  <= r_sh[7];
              r_sh  <= {r_sh[6:0], 1'b0};
            end else begin
              r_bit <= 3'd7;
              if (r_state == S_CMD) begin
                if (r_rw) begin
                  r_state <= S_DATA;
                  MOSI    <= r_wd[7];
                  r_sh    <= {r_wd[6:0], 1'b0};
                end else begin
                  r_state <= S_GAP;
                  MOSI    <= 1'b0;
                  r_cnt   <= C_GAP;
                end
              end else begin
                if (!r_rw) begin
                  r_rbuf[{r_byte, 3'b000} +: 8] <= r_rx;
                end
                if (w_last_byte) begin
                  r_state <= S_HOLD;
                  MOSI    <= 1'b0;
                end else begin
                  r_byte <= r_byte + 1'b1;
                  MOSI   <= r_wd[15];
                  r_sh   <= {r_wd[14:8], 1'b0};
                  r_wd   <= {8'h00, r_wd[31:8]};
                end
              end
            end
          end
        end
        S_GAP: begin
          if (w_cnt_zero) begin
            r_state <= S_DATA;
            r_cnt   <= C_HALF;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_HOLD: begin
          if (w_cnt_zero) begin
            r_state <= S_RECOVER;
            SS      <= 1'b1;
            r_cnt   <= C_HALF;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RECOVER: begin
          if (w_cnt_zero) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == C_ONE) begin
              done <= 1'b1;
              if (!r_rw) begin
                rdata <= r_rbuf;
              end
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
